// File: rtl/seri_alici_if.sv
// Serial link between the sequencer (y/mesgul) and the seri_alici receiver,
// together with the receiver's result signals.
interface seri_alici_if #(
    parameter int N  = 5,
    parameter int CW = 8
) ();
    logic          y;
    logic          mesgul;
    logic [N-1:0]  Q;
    logic          gecerli;
    logic          hata;
    logic          alimda;
    logic [CW-1:0] cerceve_say;

    modport master (
        output y, mesgul,
        input  Q, gecerli, hata, alimda, cerceve_say
    );

    modport slave (
        input  y, mesgul,
        output Q, gecerli, hata, alimda, cerceve_say
    );
endinterface

// File: rtl/seri_alici.sv
// Serial-to-parallel receiver: samples y LSB first while mesgul is high,
// checks the frame length and reports a good word or a framing error.
module seri_alici #(
    parameter int N  = 5,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         reset,
    seri_alici_if.slave  bus
);
    localparam int                CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        ALIM  = 2'd1,
        TASMA = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     sr;
    logic [CNT_W-1:0] cnt;
    logic             frame_full;

    assign frame_full = (cnt == CNT_FULL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOS;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            BOS: begin
                if (bus.mesgul) state_next = ALIM;
            end
            ALIM: begin
                if (!bus.mesgul)     state_next = BOS;
                else if (frame_full) state_next = TASMA;
            end
            TASMA: begin
                if (!bus.mesgul) state_next = BOS;
            end
            default: state_next = BOS;
        endcase
    end

    always_comb begin
        bus.alimda = (state != BOS);
    end

    // Datapath: shift register, saturating bit counter and registered results.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr              <= '0;
            cnt             <= '0;
            bus.Q           <= '0;
            bus.gecerli     <= 1'b0;
            bus.hata        <= 1'b0;
            bus.cerceve_say <= '0;
        end else begin
            bus.gecerli <= 1'b0;
            bus.hata    <= 1'b0;
            case (state)
                BOS: begin
                    if (bus.mesgul) begin
                        sr  <= {bus.y, sr[N-1:1]};
                        cnt <= CNT_W'(1);
                    end
                end
                ALIM: begin
                    if (bus.mesgul) begin
                        // A bit beyond N is the overrun marker and is dropped.
                        if (!frame_full) begin
                            sr  <= {bus.y, sr[N-1:1]};
                            cnt <= cnt + 1'b1;
                        end
                    end else if (frame_full) begin
                        bus.Q           <= sr;
                        bus.gecerli     <= 1'b1;
                        bus.cerceve_say <= bus.cerceve_say + 1'b1;
                    end else begin
                        bus.hata <= 1'b1;
                    end
                end
                TASMA: begin
                    if (!bus.mesgul) bus.hata <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seri_alici.sv
// Self-checking bench for seri_alici: directed frames on an N=5 and an N=8/CW=2
// instance, with a scoreboard of expected result pulses.
module tb_seri_alici;
    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [15:0] q;
        logic [7:0]  say;
    } exp_t;

    exp_t q5[$];
    exp_t q8[$];

    logic [15:0] exp_q5 = '0;
    logic [15:0] exp_q8 = '0;
    int          say5   = 0;
    int          say8   = 0;

    seri_alici_if #(.N(5), .CW(8)) b5 ();
    seri_alici_if #(.N(8), .CW(2)) b8 ();

    seri_alici #(.N(5), .CW(8)) u_dut5 (.clk(clk), .reset(reset), .bus(b5));
    seri_alici #(.N(8), .CW(2)) u_dut8 (.clk(clk), .reset(reset), .bus(b8));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic yv, input logic mv);
        if (which == 0) begin
            b5.y = yv;
            b5.mesgul = mv;
        end else begin
            b8.y = yv;
            b8.mesgul = mv;
        end
    endtask

    function automatic logic get_alimda(input int which);
        return (which == 0) ? b5.alimda : b8.alimda;
    endfunction

    // Push the expected result for this frame, then send len bits LSB first.
    task automatic send(input int which, input logic [15:0] data, input int len);
        exp_t e;
        int   n;
        n = (which == 0) ? 5 : 8;
        if (len > 0) begin
            if (len == n) begin
                if (which == 0) begin
                    exp_q5 = data & 16'h001F;
                    say5   = (say5 + 1) % 256;
                end else begin
                    exp_q8 = data & 16'h00FF;
                    say8   = (say8 + 1) % 4;
                end
            end
            e.err = (len != n);
            e.q   = (which == 0) ? exp_q5 : exp_q8;
            e.say = 8'((which == 0) ? say5 : say8);
            if (which == 0) q5.push_back(e);
            else            q8.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i > 0) check("alimda_in_frame", 32'(get_alimda(which)), 1);
            drive(which, data[i], 1'b1);
        end
        if (len > 0) begin
            @(negedge clk);
            check("alimda_last_bit", 32'(get_alimda(which)), 1);
            drive(which, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every gecerli/hata pulse must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (b5.gecerli === 1'b1 || b5.hata === 1'b1) begin
            check("pulse_expected5", 32'(q5.size() != 0), 1);
            if (q5.size() != 0) begin
                e = q5.pop_front();
                check("kind5", {30'd0, b5.gecerli, b5.hata}, e.err ? 32'd1 : 32'd2);
                check("q5", 32'(b5.Q), 32'(e.q));
                check("say5", 32'(b5.cerceve_say), 32'(e.say));
                check("alimda_after5", 32'(b5.alimda), 0);
            end
        end
        if (b8.gecerli === 1'b1 || b8.hata === 1'b1) begin
            check("pulse_expected8", 32'(q8.size() != 0), 1);
            if (q8.size() != 0) begin
                e = q8.pop_front();
                check("kind8", {30'd0, b8.gecerli, b8.hata}, e.err ? 32'd1 : 32'd2);
                check("q8", 32'(b8.Q), 32'(e.q));
                check("say8", 32'(b8.cerceve_say), 32'(e.say));
                check("alimda_after8", 32'(b8.alimda), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);

        // Reset state on both instances
        @(negedge clk);
        check("rst_q5", 32'(b5.Q), 0);
        check("rst_gecerli5", 32'(b5.gecerli), 0);
        check("rst_hata5", 32'(b5.hata), 0);
        check("rst_alimda5", 32'(b5.alimda), 0);
        check("rst_say5", 32'(b5.cerceve_say), 0);
        check("rst_q8", 32'(b8.Q), 0);
        check("rst_say8", 32'(b8.cerceve_say), 0);
        reset = 1'b1;
        idle(2);

        // Basic frame 01101
        send(0, 16'b01101, 5);
        idle(2);
        check("basic_q", 32'(b5.Q), 32'b01101);
        check("basic_say", 32'(b5.cerceve_say), 1);

        // Short frame: Q and count hold
        send(0, 16'b111, 3);
        idle(2);
        check("short_q_hold", 32'(b5.Q), 32'b01101);
        check("short_say_hold", 32'(b5.cerceve_say), 1);

        // Overrun frame of 7 bits
        send(0, 16'h007F, 7);
        idle(2);
        check("overrun_q_hold", 32'(b5.Q), 32'b01101);

        // Boundaries N-1 and N+1
        send(0, 16'b1010, 4);
        idle(1);
        send(0, 16'b101010, 6);
        idle(2);

        // Back-to-back with one idle cycle
        send(0, 16'b10010, 5);
        send(0, 16'b00111, 5);
        idle(2);
        check("b2b_q", 32'(b5.Q), 32'b00111);
        check("b2b_say", 32'(b5.cerceve_say), 3);

        // Zero-length: nothing happens
        send(0, 16'h0000, 0);
        idle(3);
        check("zero_q_hold", 32'(b5.Q), 32'b00111);
        check("zero_alimda", 32'(b5.alimda), 0);

        // Reset in the middle of a frame
        check("pre_reset_queue5", 32'(q5.size()), 0);
        @(negedge clk); drive(0, 1'b1, 1'b1);
        @(negedge clk); drive(0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b1, 1'b1);
        exp_q5 = '0;
        say5   = 0;
        #1;
        check("midrst_q", 32'(b5.Q), 0);
        check("midrst_gecerli", 32'(b5.gecerli), 0);
        check("midrst_hata", 32'(b5.hata), 0);
        check("midrst_alimda", 32'(b5.alimda), 0);
        check("midrst_say", 32'(b5.cerceve_say), 0);
        @(negedge clk);
        reset = 1'b1;
        q5.push_back('{err: 1'b1, q: 16'h0000, say: 8'd0});
        drive(0, 1'b1, 1'b1);
        @(negedge clk);
        check("postrst_alimda", 32'(b5.alimda), 1);
        drive(0, 1'b0, 1'b1);
        @(negedge clk); drive(0, 1'b0, 1'b0);
        idle(2);
        check("postrst_q", 32'(b5.Q), 0);

        // N=8, CW=2: counter wraps 1,2,3,0,1
        for (int k = 0; k < 5; k++) send(1, 16'h00A5, 8);
        idle(2);
        check("wrap_q", 32'(b8.Q), 32'hA5);
        check("wrap_say", 32'(b8.cerceve_say), 1);
        send(1, 16'h003C, 8);
        send(1, 16'h00FF, 7);
        send(1, 16'h01FF, 9);
        idle(3);
        check("n8_q_hold", 32'(b8.Q), 32'h3C);

        idle(3);
        check("queue5_drained", 32'(q5.size()), 0);
        check("queue8_drained", 32'(q8.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
